stack_sequencer: RTL and testbench

STACK_SEQUENCER -- requirements
Module: stack_sequencer

---
 rtl/stack_seq_pkg.sv | 16 +
 rtl/stack_sequencer.sv | 155 +++++++++++++++
 tb/tb_stack_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/stack_seq_pkg.sv
// Shared definitions for the stack sequencer.
// Holds the FSM state encoding and the command opcodes.
package stack_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PUSH = 3'd1,
        POP  = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

endpackage

// File: rtl/stack_sequencer.sv
// Command-to-stack sequencer: accepts one push/pop at a time, strobes an
// external stack, tracks occupancy and returns a single response per command.
module stack_sequencer
    import stack_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    input  logic                  cmd_op,
    input  logic [WIDTH-1:0]      cmd_data,
    output logic                  cmd_ready,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [WIDTH-1:0]      stk_data_in,
    input  logic [WIDTH-1:0]      stk_data_out,
    input  logic                  stk_full,
    input  logic                  stk_empty,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    input  logic                  rsp_ready,
    output logic [ADDR_WIDTH:0]   level
);

    localparam logic [ADDR_WIDTH:0] LEVEL_MAX = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LEVEL_ONE = (ADDR_WIDTH + 1)'(1);

    state_t state_r;
    state_t next_state_s;
    logic   accept_s;
    logic   push_ok_s;
    logic   push_err_s;
    logic   pop_ok_s;
    logic   pop_err_s;

    // Next-state decode and classification of the accepted command
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        push_ok_s    = 1'b0;
        push_err_s   = 1'b0;
        pop_ok_s     = 1'b0;
        pop_err_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept_s = 1'b1;
                    if (cmd_op == OP_PUSH) begin
                        if (stk_full) begin
                            push_err_s   = 1'b1;
                            next_state_s = RESP;
                        end else begin
                            push_ok_s    = 1'b1;
                            next_state_s = PUSH;
                        end
                    end else begin
                        if (stk_empty) begin
                            pop_err_s    = 1'b1;
                            next_state_s = RESP;
                        end else begin
                            pop_ok_s     = 1'b1;
                            next_state_s = POP;
                        end
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            PUSH:    next_state_s = RESP;
            POP:     next_state_s = WAIT;
            WAIT:    next_state_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register; handshake and strobe outputs are registered from the
    // next state so they are glitch-free and drop with reset asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            cmd_ready <= 1'b0;
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            cmd_ready <= (next_state_s == IDLE);
            stk_push  <= (next_state_s == PUSH);
            stk_pop   <= (next_state_s == POP);
            rsp_valid <= (next_state_s == RESP);
        end
    end

    // Push word latch; only reloaded when a real push is about to be issued
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stk_data_in <= {WIDTH{1'b0}};
        end else if (push_ok_s) begin
            stk_data_in <= cmd_data;
        end else begin
            stk_data_in <= stk_data_in;
        end
    end

    // Response payload and error flag; held while waiting in RESP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_data <= {WIDTH{1'b0}};
            rsp_err  <= 1'b0;
        end else if (push_err_s) begin
            rsp_data <= cmd_data;
            rsp_err  <= 1'b1;
        end else if (pop_err_s) begin
            rsp_data <= {WIDTH{1'b0}};
            rsp_err  <= 1'b1;
        end else if (state_r == PUSH) begin
            rsp_data <= stk_data_in;
            rsp_err  <= 1'b0;
        end else if (state_r == WAIT) begin
            rsp_data <= stk_data_out;
            rsp_err  <= 1'b0;
        end else begin
            rsp_data <= rsp_data;
            rsp_err  <= rsp_err;
        end
    end

    // Saturating occupancy tracker, updated when the push/pop completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= '0;
        end else if ((state_r == PUSH) && (level != LEVEL_MAX)) begin
            level <= level + LEVEL_ONE;
        end else if ((state_r == WAIT) && (level != '0)) begin
            level <= level - LEVEL_ONE;
        end else begin
            level <= level;
        end
    end

    logic unused_s;
    assign unused_s = accept_s ^ pop_ok_s;

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer with a behavioural stack attached,
// a directed vector table, hand-written reset/stall sequences and random traffic.
module tb_stack_sequencer;
    import stack_seq_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_ready;
    logic             stk_push;
    logic             stk_pop;
    logic [WIDTH-1:0] stk_data_in;
    logic [WIDTH-1:0] stk_data_out;
    logic             stk_full;
    logic             stk_empty;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic             rsp_ready;
    logic [AW:0]      level;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    stack_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
        .stk_data_out(stk_data_out), .stk_full(stk_full), .stk_empty(stk_empty),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready), .level(level)
    );

    // External stack shares the sequencer reset
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW:0]      stk_cnt;
    assign stk_full  = (stk_cnt == 4'd8);
    assign stk_empty = (stk_cnt == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stk_cnt      <= 4'd0;
            stk_data_out <= 8'd0;
        end else if (stk_push && !stk_full) begin
            mem[stk_cnt[AW-1:0]] <= stk_data_in;
            stk_cnt              <= stk_cnt + 4'd1;
        end else if (stk_pop && !stk_empty) begin
            stk_data_out <= mem[3'(stk_cnt - 4'd1)];
            stk_cnt      <= stk_cnt - 4'd1;
        end
    end

    // Reference model: a plain queue of words
    logic [WIDTH-1:0] mq[$];

    task automatic model(input logic op, input logic [WIDTH-1:0] d,
                         output logic e_err, output logic [WIDTH-1:0] e_data,
                         output int e_lat, output int e_push, output int e_pop, output int e_lvl);
        e_push = 0; e_pop = 0;
        if (op == OP_PUSH) begin
            if (mq.size() >= DEPTH) begin
                e_err = 1'b1; e_data = d; e_lat = 1;
            end else begin
                mq.push_back(d);
                e_err = 1'b0; e_data = d; e_lat = 2; e_push = 1;
            end
        end else begin
            if (mq.size() == 0) begin
                e_err = 1'b1; e_data = 8'd0; e_lat = 1;
            end else begin
                e_data = mq.pop_back();
                e_err = 1'b0; e_lat = 3; e_pop = 1;
            end
        end
        e_lvl = mq.size();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full command: accept, observe strobes/latency, optional stall, handshake
    task automatic run_cmd(input logic op, input logic [WIDTH-1:0] data, input int delay,
                           output logic err, output logic [WIDTH-1:0] rdata, output int lat,
                           output int npush, output int npop, output int lvl);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom);
        lat = 0; npush = 0; npop = 0;
        do begin
            @(negedge clk);
            lat++;
            if (stk_push) npush++;
            if (stk_pop) npop++;
            if (stk_push && stk_pop) check("push_pop_overlap", 32'd1, 32'd0);
        end while (!rsp_valid && lat < 20);
        err = rsp_err; rdata = rsp_data; lvl = int'(level);
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_rsp_data", {24'd0, rsp_data}, {24'd0, rdata});
            check("stall_rsp_err", {31'd0, rsp_err}, {31'd0, err});
            check("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("stall_no_strobe", {30'd0, stk_push, stk_pop}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
        check("cmd_ready_b2b", {31'd0, cmd_ready}, 32'd1);
    endtask

    // Runs a command and compares against both explicit expectations and the model
    task automatic cmd_checked(input string tag, input logic op, input logic [WIDTH-1:0] d,
                               input int delay, input logic use_exp, input logic x_err,
                               input logic [WIDTH-1:0] x_data, input int x_lvl);
        logic e_err, a_err;
        logic [WIDTH-1:0] e_data, a_data;
        int e_lat, e_push, e_pop, e_lvl, a_lat, a_push, a_pop, a_lvl;
        model(op, d, e_err, e_data, e_lat, e_push, e_pop, e_lvl);
        if (use_exp) begin
            e_err = x_err; e_data = x_data; e_lvl = x_lvl;
        end
        run_cmd(op, d, delay, a_err, a_data, a_lat, a_push, a_pop, a_lvl);
        check({tag, "_err"},   {31'd0, a_err}, {31'd0, e_err});
        check({tag, "_data"},  {24'd0, a_data}, {24'd0, e_data});
        check({tag, "_lat"},   a_lat, e_lat);
        check({tag, "_push"},  a_push, e_push);
        check({tag, "_pop"},   a_pop, e_pop);
        check({tag, "_level"}, a_lvl, e_lvl);
    endtask

    typedef struct {
        logic             op;
        logic [WIDTH-1:0] data;
        int               delay;
        logic             exp_err;
        logic [WIDTH-1:0] exp_data;
        int               exp_lvl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic op, input logic [WIDTH-1:0] d, input int dl,
                                input logic e, input logic [WIDTH-1:0] ed, input int el);
        vec_t v;
        v.op = op; v.data = d; v.delay = dl; v.exp_err = e; v.exp_data = ed; v.exp_lvl = el;
        return v;
    endfunction

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_data = 8'd0; rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_outputs", {cmd_ready, stk_push, stk_pop, rsp_valid, rsp_err}, 32'd0);
        check("rst_data", {stk_data_in, rsp_data, 4'd0, level}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", {31'd0, cmd_ready}, 32'd1);

        vecs.push_back(mk(OP_PUSH, 8'd10, 0, 1'b0, 8'd10, 1));
        vecs.push_back(mk(OP_PUSH, 8'd20, 0, 1'b0, 8'd20, 2));
        vecs.push_back(mk(OP_PUSH, 8'd30, 0, 1'b0, 8'd30, 3));
        vecs.push_back(mk(OP_POP,  8'hAA, 0, 1'b0, 8'd30, 2));
        vecs.push_back(mk(OP_POP,  8'hBB, 5, 1'b0, 8'd20, 1));
        vecs.push_back(mk(OP_POP,  8'hCC, 0, 1'b0, 8'd10, 0));
        vecs.push_back(mk(OP_POP,  8'hDD, 1, 1'b1, 8'd0,  0));
        for (int i = 1; i <= 8; i++) begin
            vecs.push_back(mk(OP_PUSH, 8'(i * 17), 0, 1'b0, 8'(i * 17), i));
        end
        vecs.push_back(mk(OP_PUSH, 8'h99, 2, 1'b1, 8'h99, 8));

        for (int i = 0; i < vecs.size(); i++) begin
            cmd_checked($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].delay,
                        1'b1, vecs[i].exp_err, vecs[i].exp_data, vecs[i].exp_lvl);
        end

        // Reset asserted while the pop strobe is high
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_POP;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("pop_strobe_before_reset", {31'd0, stk_pop}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_ctrl", {cmd_ready, stk_push, stk_pop, rsp_valid, rsp_err}, 32'd0);
        check("abort_data", {stk_data_in, rsp_data, 4'd0, level}, 32'd0);
        mq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_abort", {31'd0, cmd_ready}, 32'd1);
        cmd_checked("post_push40", OP_PUSH, 8'd40, 0, 1'b1, 1'b0, 8'd40, 1);
        cmd_checked("post_pop40",  OP_POP,  8'd0,  0, 1'b1, 1'b0, 8'd40, 0);

        // Random traffic against the queue model
        for (int i = 0; i < 80; i++) begin
            logic op;
            op = ($urandom_range(0, 99) < ((i / 20) % 2 == 0 ? 65 : 35)) ? OP_PUSH : OP_POP;
            cmd_checked($sformatf("rnd%0d", i), op, 8'($urandom), int'($urandom_range(0, 2)),
                        1'b0, 1'b0, 8'd0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
